// File: rtl/param_ring_router.sv
// Three-port ring router (cw, ccw, pe) with two polarity-phased VC FIFOs per input and one output register per link.
// Optional macro RING_PRIORITY_EN: cw/ccw outputs give the ring input fixed priority over pe.
module param_ring_router #(
    parameter int PAC_WIDTH = 64,
    parameter int BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 polarity,
    input  logic                 cwsi,
    input  logic                 ccwsi,
    input  logic                 pesi,
    output logic                 cwri,
    output logic                 ccwri,
    output logic                 peri,
    input  logic [PAC_WIDTH-1:0] cwdi,
    input  logic [PAC_WIDTH-1:0] ccwdi,
    input  logic [PAC_WIDTH-1:0] pedi,
    output logic                 cwso,
    output logic                 ccwso,
    output logic                 peso,
    input  logic                 cwro,
    input  logic                 ccwro,
    input  logic                 pero,
    output logic [PAC_WIDTH-1:0] cwdo,
    output logic [PAC_WIDTH-1:0] ccwdo,
    output logic [PAC_WIDTH-1:0] pedo
);
    localparam int AW     = $clog2(BUF_DEPTH);
    localparam int HOP_HI = PAC_WIDTH - 9;
    localparam int HOP_LO = PAC_WIDTH - 16;
    localparam int IN_PE  = 2;
    // Requesters per output (index 0 = cw, 1 = ccw, 2 = pe); A is the ring side.
    localparam int REQ_A [3] = '{0, 1, 0};
    localparam int REQ_B [3] = '{2, 2, 1};
`ifdef RING_PRIORITY_EN
    localparam logic [2:0] FIXED_PRIO = 3'b011;
`else
    localparam logic [2:0] FIXED_PRIO = 3'b000;
`endif

    typedef logic [PAC_WIDTH-1:0] pkt_t;
    typedef logic [AW:0]          ptr_t;

    pkt_t       mem_q    [3][2][BUF_DEPTH];
    pkt_t       mem_d    [3][2][BUF_DEPTH];
    ptr_t       wr_ptr_q [3][2];
    ptr_t       wr_ptr_d [3][2];
    ptr_t       rd_ptr_q [3][2];
    ptr_t       rd_ptr_d [3][2];
    logic [2:0] out_vld_q, out_vld_d;
    pkt_t       out_dat_q [3];
    pkt_t       out_dat_d [3];
    logic [2:0] rr_q, rr_d;

    logic [2:0] in_send, in_rdy, push, pop, head_vld, out_ro;
    pkt_t       in_dat [3];
    pkt_t       head   [3];
    pkt_t       fwd    [3];
    logic [1:0] dest   [3];
    logic       full   [3][2];
    logic       empty  [3][2];

    assign in_send   = {pesi, ccwsi, cwsi};
    assign out_ro    = {pero, ccwro, cwro};
    assign in_dat[0] = cwdi;
    assign in_dat[1] = ccwdi;
    assign in_dat[2] = pedi;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int v = 0; v < 2; v++) begin
                full[i][v]  = (wr_ptr_q[i][v][AW] != rd_ptr_q[i][v][AW]) &&
                              (wr_ptr_q[i][v][AW-1:0] == rd_ptr_q[i][v][AW-1:0]);
                empty[i][v] = (wr_ptr_q[i][v] == rd_ptr_q[i][v]);
            end
        end
    end

    // Inputs write VC[polarity]; only heads of VC[~polarity] are routed this cycle.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            in_rdy[i]   = ~reset & ~full[i][polarity];
            push[i]     = in_send[i] & in_rdy[i];
            head[i]     = mem_q[i][~polarity][rd_ptr_q[i][~polarity][AW-1:0]];
            head_vld[i] = ~empty[i][~polarity];
            fwd[i]      = head[i];
            dest[i]     = 2'd2;
            if (i == IN_PE) begin
                dest[i] = head[i][PAC_WIDTH-2] ? 2'd1 : 2'd0;
            end else if (head[i][HOP_HI:HOP_LO] != 8'd0) begin
                dest[i] = 2'(i);
                fwd[i][HOP_HI:HOP_LO] = head[i][HOP_HI:HOP_LO] - 8'd1;
            end
        end
    end

    always_comb begin
        logic ra, rb, ga, gb, can_load;
        ra        = 1'b0;
        rb        = 1'b0;
        ga        = 1'b0;
        gb        = 1'b0;
        can_load  = 1'b0;
        pop       = '0;
        rr_d      = rr_q;
        out_vld_d = out_vld_q & ~out_ro;
        out_dat_d = out_dat_q;
        for (int o = 0; o < 3; o++) begin
            ra       = head_vld[REQ_A[o]] && (dest[REQ_A[o]] == 2'(o));
            rb       = head_vld[REQ_B[o]] && (dest[REQ_B[o]] == 2'(o));
            can_load = ~out_vld_q[o] | out_ro[o];
            ga       = ra & (~rb | ~rr_q[o] | FIXED_PRIO[o]);
            gb       = rb & ~ga;
            if (can_load && (ga || gb)) begin
                out_vld_d[o] = 1'b1;
                out_dat_d[o] = ga ? fwd[REQ_A[o]] : fwd[REQ_B[o]];
                if (ga) pop[REQ_A[o]] = 1'b1;
                else    pop[REQ_B[o]] = 1'b1;
                // Pointer turns to the loser only under real contention.
                if (ra && rb && !FIXED_PRIO[o]) rr_d[o] = ga;
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem_d[i][polarity][wr_ptr_q[i][polarity][AW-1:0]] = in_dat[i];
                wr_ptr_d[i][polarity] = wr_ptr_q[i][polarity] + ptr_t'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i][~polarity] = rd_ptr_q[i][~polarity] + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q  <= '{default: '0};
            rd_ptr_q  <= '{default: '0};
            out_vld_q <= '0;
            out_dat_q <= '{default: '0};
            rr_q      <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            rr_q      <= rr_d;
        end
    end

    assign cwri  = in_rdy[0];
    assign ccwri = in_rdy[1];
    assign peri  = in_rdy[2];
    assign cwso  = out_vld_q[0];
    assign ccwso = out_vld_q[1];
    assign peso  = out_vld_q[2];
    assign cwdo  = out_dat_q[0];
    assign ccwdo = out_dat_q[1];
    assign pedo  = out_dat_q[2];

endmodule

// File: doc/param_ring_router.md
PARAM_RING_ROUTER -- requirements
Module: param_ring_router

Interface
REQ-001 SHALL have parameter PAC_WIDTH, default 64, packet width in bits; legal values are 17 or more.
REQ-002 SHALL have parameter BUF_DEPTH, default 4, entries per virtual-channel (VC) FIFO; legal values are powers of 2, 2 or more.
REQ-003 SHALL have port clk  in  1  clock, all logic on the rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port polarity  in  1  VC phase; it toggles every cycle and is driven externally.
REQ-006 SHALL have ports cwsi/ccwsi/pesi  in  1  input-link send (valid).
REQ-007 SHALL have ports cwri/ccwri/peri  out  1  input-link ready.
REQ-008 SHALL have ports cwdi/ccwdi/pedi  in  PAC_WIDTH  input-link packet.
REQ-009 SHALL have ports cwso/ccwso/peso  out  1  output-link send (valid).
REQ-010 SHALL have ports cwro/ccwro/pero  in  1  output-link ready.
REQ-011 SHALL have ports cwdo/ccwdo/pedo  out  PAC_WIDTH  output-link packet.

Function
REQ-012 Packet fields SHALL be: vc = [W-1]; dir = [W-2] (0 = clockwise, 1 = counter-clockwise); hop = [W-9:W-16] (8 bits); payload = the remaining bits. W is PAC_WIDTH.
REQ-013 Each input (cw, ccw, pe) SHALL own two FIFOs, VC0 and VC1, each BUF_DEPTH deep.
REQ-014 xri SHALL equal NOT full of that input's FIFO[polarity]; it is a combinational function of polarity and state only.
REQ-015 On an edge with xsi=1 and xri=1, the input SHALL push xdi into FIFO[polarity] unchanged. If xsi=1 and xri=0, the packet SHALL be ignored and the sender holds it.
REQ-016 In each cycle the router SHALL arbitrate only the heads of FIFO[~polarity], so a VC is never written and read in the same cycle.
REQ-017 Routing from the cw input (and identically from the ccw input): hop==0 SHALL request PE out; hop>0 SHALL request the same-direction ring output with hop decremented by 1.
REQ-018 Routing from the pe input SHALL be: dir=0 requests cw out; dir=1 requests ccw out; hop is passed unchanged.
REQ-019 Each output SHALL have one output register. It SHALL load when empty, or when xso=1 and xro=1 on the same edge (back-to-back throughput of 1 packet per cycle).
REQ-020 xso SHALL be 1 exactly while the output register holds a packet. xdo SHALL stay stable while xso=1 and xro=0.
REQ-021 Each output has two possible requesters: cw out is requested by cw and pe; ccw out by ccw and pe; pe out by cw and ccw. Arbitration SHALL use a 1-bit round-robin pointer per output.
REQ-022 On a round-robin grant, the pointer SHALL move to the non-granted requester only when both requesters asserted.
REQ-023 A head packet that is not granted, or whose output cannot load, SHALL remain in its FIFO. It SHALL NOT block the other VC.
REQ-024 A granted head SHALL be popped on the same edge that loads the output register.
REQ-025 Latency: a packet pushed at edge E with no contention and a free output SHALL load at edge E+1. xso SHALL be 1 in the cycle after E+1.
REQ-026 Hop arithmetic SHALL be 8-bit unsigned; hop==0 is never decremented, so there is no wrap.

Reset
REQ-027 While reset=1, all FIFOs SHALL be emptied, all xso=0, all xdo=0, and all round-robin pointers=0. A reset asserted mid-transfer SHALL discard every buffered packet.
REQ-028 While reset=1, all xri SHALL be 0. On the first cycle after reset, all xri SHALL be 1.

Configuration
REQ-029 Macro RING_PRIORITY_EN: when defined, the cw and ccw outputs SHALL grant the ring input over pe with fixed priority. pe out SHALL remain round-robin.
REQ-030 When RING_PRIORITY_EN is undefined, all three outputs SHALL use round-robin per REQ-021 and REQ-022.

Verification
REQ-031 Scenario, cw forwarding: polarity toggling, cwsi=1 for 10 cycles, cwdi hop=1 with alternating vc -> cwdo carries each packet with hop=0 and payload intact, 2 edges after acceptance, in order.
REQ-032 Scenario, ccw hops: ccwdi hop=3 -> ccwdo hop=2. Scenario, ejection: ccwdi hop=0 -> pedo carries the packet unchanged and ccwso stays 0.
REQ-033 Scenario, PE injection: pesi=1 with dir alternating 0/1 each cycle and hop=1 -> packets alternate between cwdo and ccwdo, hop=1 preserved.
REQ-034 Scenario, congestion: cwsi=pesi=1 continuously, both targeting cw out. Without the macro, grants alternate cw/pe. With RING_PRIORITY_EN, only cw packets are granted while cw has packets.
REQ-035 Scenario, backpressure and reset: cwro=0 while 2*BUF_DEPTH+1 packets are offered -> cwri=0 once both VCs are full, with no loss or reorder after cwro=1. Asserting reset mid-stream -> every xso=0 on the next cycle and no stale packet is emitted afterwards.
